wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL use these ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous, active-high reset
- rdy_in  in  1  global stall; block frozen when low
- clear  in  1  mispredict flush from ROB
- alu_valid / alu_ready  in / out  1 / 1  ALU writeback handshake
- alu_rob_id / alu_value  in  ROB_WIDTH / 32  ALU result tag and value
- br_valid / br_ready  in / out  1 / 1  branch-unit writeback handshake
- br_rob_id / br_value  in  ROB_WIDTH / 32  branch tag and resolved target
- lsb_valid / lsb_ready  in / out  1 / 1  LSB writeback handshake
- lsb_rob_id / lsb_value  in  ROB_WIDTH / 32  LSB tag and load data
- cdb_valid  out  1  registered broadcast valid, to ROB and RS
- cdb_src  out  2  winning requester: 0=ALU, 1=BR, 2=LSB
- cdb_rob_id / cdb_value  out  ROB_WIDTH / 32  registered broadcast payload
REQ-002 There is one clock. Reset is asynchronous and active-high on rst_in. Both are fixed.

Function
REQ-003 Each requester i in {0,1,2} SHALL own one holding slot: full_i, rob_id_i, value_i.
REQ-004 ready_i SHALL equal rdy_in && !clear && (!full_i || grant_i), where grant_i is the combinational grant of the current cycle.
REQ-005 A transfer SHALL occur at a rising edge when valid_i && ready_i. It SHALL load the slot and set full_i, including when the same slot is draining in that cycle (back-to-back).
REQ-006 Arbitration SHALL be combinational round-robin over full slots. Priority starts at rr and runs rr, rr+1, rr+2 mod 3. At most one grant per cycle.
REQ-007 On a grant to i, at the edge: cdb_valid<=1, cdb_src<=i, cdb_rob_id<=rob_id_i, cdb_value<=value_i, full_i<=0 (unless reloaded per REQ-005), and rr<=(i+1) mod 3, with 2 wrapping to 0.
REQ-008 With no full slot, the block SHALL set cdb_valid<=0. rr and the payload registers SHALL hold.
REQ-009 Latency SHALL be exactly 1 cycle when uncontended: accepted at edge k, broadcast valid after edge k+1. Worst case is 3 cycles with all slots full.
REQ-010 With rdy_in low, all state SHALL hold, including cdb_valid. All ready outputs SHALL be 0.
REQ-011 With clear && rdy_in, at the edge: all full_i<=0, cdb_valid<=0, rr<=0. Inputs presented in that cycle are not accepted. No grant is issued.
REQ-012 rr SHALL never take value 3. A value of 3 SHALL be treated as 0.
REQ-013 A single requester held valid every cycle SHALL achieve one broadcast per cycle.

Reset
REQ-014 While rst_in is high, asynchronously: full_i=0, rr=0, cdb_valid=0, cdb_src=0, cdb_rob_id=0, cdb_value=0.
REQ-015 Ready outputs SHALL be 0 during reset. They SHALL follow REQ-004 from the first edge after rst_in falls.
REQ-016 Reset asserted mid-operation SHALL discard all held results. No broadcast SHALL follow the deassertion of reset.

Structure
REQ-017 The shared definitions header SHALL hold ROB_WIDTH, ROB_SIZE, and the source encodings SRC_ALU=0, SRC_BR=1, SRC_LSB=2.
REQ-018 The block SHALL contain one sub-module, rr_pick3. It is purely combinational: inputs req[2:0] and rr[1:0]; outputs gnt[2:0] (one-hot or zero).
REQ-019 Slots and output registers SHALL reside in wb_arbiter. The design SHALL be 120-400 lines of RTL.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Solo ALU: alu id=5, value=0x1234 at edge 1 -> cdb_valid=1, src=0, id=5, value=0x1234 after edge 2, then cdb_valid=0.
- Three-way collision, rr=0: ALU id=1, BR id=2, LSB id=3 at the same edge -> broadcasts on 3 consecutive cycles in order 1,2,3. rr ends at 0 (wrap). br_ready and lsb_ready are 0 while their slots are held.
- Rotation fairness: ALU and LSB valid every cycle for 6 cycles -> cdb_src alternates 0,2,0,2,... and neither source is granted twice in a row.
- Flush: BR and LSB slots full and clear=1 with rdy_in=1 -> next cycle cdb_valid=0, all ready=1, and neither held tag is ever broadcast.
- Stall: slot full, rdy_in=0 for 4 cycles -> cdb outputs and ready=0 frozen; broadcast occurs the edge after rdy_in returns to 1.
- Async reset mid-burst: rst_in pulsed between edges with all slots full -> cdb_valid=0 immediately. No broadcast after release until new valid input.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: ROB tag sizing, source
// encodings and small helpers for the round-robin pointer.
package wb_arbiter_pkg;

  localparam int unsigned ROB_SIZE  = 16;
  localparam int unsigned ROB_WIDTH = $clog2(ROB_SIZE);

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_BR  = 2'd1;
  localparam logic [1:0] SRC_LSB = 2'd2;

  // Priority pointer advances past the winner, wrapping 2 -> 0.
  function automatic logic [1:0] rr_next(input logic [1:0] src);
    return (src >= 2'd2) ? 2'd0 : src + 2'd1;
  endfunction

  function automatic logic [1:0] onehot_to_src(input logic [2:0] oh);
    if (oh[1]) return SRC_BR;
    if (oh[2]) return SRC_LSB;
    return SRC_ALU;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational three-way round-robin picker: first set request starting at
// rr and wrapping upward; an rr of 3 behaves as 0.
module rr_pick3 (
  input  logic [2:0] req,
  input  logic [1:0] rr,
  output logic [2:0] gnt
);

  logic [2:0] req_rot;
  logic [2:0] gnt_rot;

  // Rotate so the highest-priority requester lands in bit 0.
  always_comb begin
    case (rr)
      2'd1:    req_rot = {req[0], req[2], req[1]};
      2'd2:    req_rot = {req[1], req[0], req[2]};
      default: req_rot = req;
    endcase
  end

  always_comb begin
    gnt_rot = 3'b000;
    if (req_rot[0])      gnt_rot = 3'b001;
    else if (req_rot[1]) gnt_rot = 3'b010;
    else if (req_rot[2]) gnt_rot = 3'b100;
  end

  always_comb begin
    case (rr)
      2'd1:    gnt = {gnt_rot[1], gnt_rot[0], gnt_rot[2]};
      2'd2:    gnt = {gnt_rot[0], gnt_rot[2], gnt_rot[1]};
      default: gnt = gnt_rot;
    endcase
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one holding slot per execution unit, round-robin onto a
// single registered common data bus.
module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [ROB_WIDTH-1:0] alu_rob_id,
  input  logic [31:0]          alu_value,
  input  logic                 br_valid,
  output logic                 br_ready,
  input  logic [ROB_WIDTH-1:0] br_rob_id,
  input  logic [31:0]          br_value,
  input  logic                 lsb_valid,
  output logic                 lsb_ready,
  input  logic [ROB_WIDTH-1:0] lsb_rob_id,
  input  logic [31:0]          lsb_value,
  output logic                 cdb_valid,
  output logic [1:0]           cdb_src,
  output logic [ROB_WIDTH-1:0] cdb_rob_id,
  output logic [31:0]          cdb_value
);

  logic [2:0]           full_q;
  logic [ROB_WIDTH-1:0] rob_id_q [3];
  logic [31:0]          value_q  [3];
  logic [1:0]           rr_q;

  logic [2:0]           valid;
  logic [2:0]           gnt;
  logic [2:0]           ready;
  logic [2:0]           xfer;
  logic                 active;
  logic [ROB_WIDTH-1:0] in_id    [3];
  logic [31:0]          in_value [3];
  logic [1:0]           win_src;
  logic [ROB_WIDTH-1:0] win_id;
  logic [31:0]          win_value;

  assign valid       = {lsb_valid, br_valid, alu_valid};
  assign in_id[0]    = alu_rob_id;
  assign in_id[1]    = br_rob_id;
  assign in_id[2]    = lsb_rob_id;
  assign in_value[0] = alu_value;
  assign in_value[1] = br_value;
  assign in_value[2] = lsb_value;

  rr_pick3 u_pick (
    .req (full_q),
    .rr  (rr_q),
    .gnt (gnt)
  );

  // A slot may accept while draining, which gives one broadcast per cycle.
  assign active = rdy_in && !clear && !rst_in;
  assign ready  = {3{active}} & (~full_q | gnt);
  assign xfer   = valid & ready;

  assign alu_ready = ready[0];
  assign br_ready  = ready[1];
  assign lsb_ready = ready[2];

  assign win_src = onehot_to_src(gnt);

  always_comb begin
    unique case (gnt)
      3'b010: begin
        win_id    = rob_id_q[1];
        win_value = value_q[1];
      end
      3'b100: begin
        win_id    = rob_id_q[2];
        win_value = value_q[2];
      end
      default: begin
        win_id    = rob_id_q[0];
        win_value = value_q[0];
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      full_q     <= '0;
      rr_q       <= '0;
      cdb_valid  <= 1'b0;
      cdb_src    <= '0;
      cdb_rob_id <= '0;
      cdb_value  <= '0;
      for (int i = 0; i < 3; i++) begin
        rob_id_q[i] <= '0;
        value_q[i]  <= '0;
      end
    end else if (rdy_in) begin
      if (clear) begin
        full_q    <= '0;
        rr_q      <= '0;
        cdb_valid <= 1'b0;
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (xfer[i]) begin
            full_q[i]   <= 1'b1;
            rob_id_q[i] <= in_id[i];
            value_q[i]  <= in_value[i];
          end else if (gnt[i]) begin
            full_q[i] <= 1'b0;
          end
        end
        if (|gnt) begin
          cdb_valid  <= 1'b1;
          cdb_src    <= win_src;
          cdb_rob_id <= win_id;
          cdb_value  <= win_value;
          rr_q       <= rr_next(win_src);
        end else begin
          cdb_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized
// traffic against a slot-level behavioural model.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic                 clk_in = 1'b0;
  logic                 rst_in = 1'b1;
  logic                 rdy_in = 1'b0;
  logic                 clear  = 1'b0;
  logic                 tv   [3];
  logic [ROB_WIDTH-1:0] tid  [3];
  logic [31:0]          tval [3];

  logic                 alu_ready, br_ready, lsb_ready;
  logic                 cdb_valid;
  logic [1:0]           cdb_src;
  logic [ROB_WIDTH-1:0] cdb_rob_id;
  logic [31:0]          cdb_value;
  logic [2:0]           rdy_vec;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit                   m_full [3];
  logic [ROB_WIDTH-1:0] m_id   [3];
  logic [31:0]          m_val  [3];
  int                   m_rr;
  logic                 m_cv;
  logic [1:0]           m_src;
  logic [ROB_WIDTH-1:0] m_cid;
  logic [31:0]          m_cval;

  assign rdy_vec = {lsb_ready, br_ready, alu_ready};

  always #5 clk_in = ~clk_in;

  wb_arbiter dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .clear      (clear),
    .alu_valid  (tv[0]),
    .alu_ready  (alu_ready),
    .alu_rob_id (tid[0]),
    .alu_value  (tval[0]),
    .br_valid   (tv[1]),
    .br_ready   (br_ready),
    .br_rob_id  (tid[1]),
    .br_value   (tval[1]),
    .lsb_valid  (tv[2]),
    .lsb_ready  (lsb_ready),
    .lsb_rob_id (tid[2]),
    .lsb_value  (tval[2]),
    .cdb_valid  (cdb_valid),
    .cdb_src    (cdb_src),
    .cdb_rob_id (cdb_rob_id),
    .cdb_value  (cdb_value)
  );

  function automatic int m_grant();
    if (rst_in || !rdy_in || clear) return -1;
    for (int k = 0; k < 3; k++) begin
      if (m_full[(m_rr + k) % 3]) return (m_rr + k) % 3;
    end
    return -1;
  endfunction

  function automatic logic [2:0] m_ready();
    logic [2:0] r;
    int g;
    g = m_grant();
    for (int i = 0; i < 3; i++)
      r[i] = !rst_in && rdy_in && !clear && (!m_full[i] || g == i);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_full[i] = 1'b0;
      m_id[i]   = '0;
      m_val[i]  = '0;
    end
    m_rr = 0; m_cv = 1'b0; m_src = '0; m_cid = '0; m_cval = '0;
  endtask

  task automatic model_edge();
    logic [2:0] acc;
    int g;
    acc = m_ready();
    g   = m_grant();
    if (rdy_in && clear) begin
      for (int i = 0; i < 3; i++) m_full[i] = 1'b0;
      m_cv = 1'b0;
      m_rr = 0;
    end else if (rdy_in) begin
      if (g >= 0) begin
        m_cv = 1'b1; m_src = 2'(g); m_cid = m_id[g]; m_cval = m_val[g];
        m_full[g] = 1'b0;
        m_rr = (g + 1) % 3;
      end else begin
        m_cv = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
        if (tv[i] && acc[i]) begin
          m_full[i] = 1'b1; m_id[i] = tid[i]; m_val[i] = tval[i];
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
  endtask

  task automatic set_idle();
    rdy_in = 1'b1;
    clear  = 1'b0;
    for (int i = 0; i < 3; i++) tv[i] = 1'b0;
  endtask

  // Flush cycle so each scenario starts with empty slots and rr = 0.
  task automatic flush_cycle();
    set_idle();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    set_idle();
    tv[0] = 1'b1; tid[0] = '1; tval[0] = 32'hdead_beef;
    #2;
    checks++;
    if (cdb_valid !== 1'b0 || cdb_src !== 2'd0 || cdb_rob_id !== '0 || cdb_value !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b src=%0d id=%0d val=%h want all zero",
               cdb_valid, cdb_src, cdb_rob_id, cdb_value);
    end
    checks++;
    if (rdy_vec !== 3'b000) begin
      errors++;
      $display("FAIL reset_ready: got %b want 000", rdy_vec);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    set_idle();
    #1;
    checks++;
    if (rdy_vec !== 3'b111) begin
      errors++;
      $display("FAIL post_reset_ready: got %b want 111", rdy_vec);
    end
  endtask

  task automatic test_solo_alu();
    set_idle();
    tv[0] = 1'b1; tid[0] = ROB_WIDTH'(5); tval[0] = 32'h1234;
    #1;
    checks++;
    if (alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL solo_ready: got %b want 1", alu_ready);
    end
    step();
    set_idle();
    checks++;
    if (cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL solo_early: got v=%b want 0", cdb_valid);
    end
    step();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_src !== SRC_ALU || cdb_rob_id !== ROB_WIDTH'(5) ||
        cdb_value !== 32'h1234) begin
      errors++;
      $display("FAIL solo_bcast: got v=%b src=%0d id=%0d val=%h want v=1 src=0 id=5 val=1234",
               cdb_valid, cdb_src, cdb_rob_id, cdb_value);
    end
    step();
    checks++;
    if (cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL solo_after: got v=%b want 0", cdb_valid);
    end
  endtask

  task automatic test_collision();
    flush_cycle();
    for (int i = 0; i < 3; i++) begin
      tv[i] = 1'b1; tid[i] = ROB_WIDTH'(i + 1); tval[i] = $urandom;
    end
    step();
    set_idle();
    #1;
    checks++;
    if (rdy_vec !== 3'b001) begin
      errors++;
      $display("FAIL coll_ready_held: got %b want 001", rdy_vec);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (cdb_valid !== 1'b1 || cdb_src !== 2'(c) || cdb_rob_id !== ROB_WIDTH'(c + 1) ||
          cdb_value !== m_cval) begin
        errors++;
        $display("FAIL coll_order%0d: got v=%b src=%0d id=%0d val=%h want v=1 src=%0d id=%0d val=%h",
                 c, cdb_valid, cdb_src, cdb_rob_id, cdb_value, c, c + 1, m_cval);
      end
      if (c == 0) begin
        checks++;
        if (lsb_ready !== 1'b0) begin
          errors++;
          $display("FAIL coll_lsb_ready: got %b want 0", lsb_ready);
        end
      end
    end
    // rr must have wrapped to 0: ALU beats BR on the next tie.
    tv[0] = 1'b1; tid[0] = ROB_WIDTH'(6);
    tv[1] = 1'b1; tid[1] = ROB_WIDTH'(7);
    step();
    set_idle();
    step();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_src !== SRC_ALU || cdb_rob_id !== ROB_WIDTH'(6)) begin
      errors++;
      $display("FAIL coll_wrap: got v=%b src=%0d id=%0d want v=1 src=0 id=6",
               cdb_valid, cdb_src, cdb_rob_id);
    end
    step();
    step();
  endtask

  task automatic test_rotation();
    logic [1:0] prev;
    logic [1:0] exp;
    flush_cycle();
    prev = 2'd3;
    for (int c = 1; c <= 6; c++) begin
      tv[0] = 1'b1; tid[0] = ROB_WIDTH'($urandom); tval[0] = $urandom;
      tv[2] = 1'b1; tid[2] = ROB_WIDTH'($urandom); tval[2] = $urandom;
      step();
      if (c >= 2) begin
        exp = (c % 2 == 0) ? SRC_ALU : SRC_LSB;
        checks++;
        if (cdb_valid !== 1'b1 || cdb_src !== exp || cdb_src === prev ||
            cdb_rob_id !== m_cid || cdb_value !== m_cval) begin
          errors++;
          $display("FAIL rotate%0d: got v=%b src=%0d id=%0d want v=1 src=%0d id=%0d",
                   c, cdb_valid, cdb_src, cdb_rob_id, exp, m_cid);
        end
        prev = cdb_src;
      end
    end
    set_idle();
    step();
    step();
    step();
  endtask

  task automatic test_flush();
    flush_cycle();
    tv[1] = 1'b1; tid[1] = ROB_WIDTH'(9);  tval[1] = 32'h9999;
    tv[2] = 1'b1; tid[2] = ROB_WIDTH'(10); tval[2] = 32'haaaa;
    step();
    set_idle();
    clear = 1'b1;
    #1;
    checks++;
    if (rdy_vec !== 3'b000) begin
      errors++;
      $display("FAIL flush_ready_during: got %b want 000", rdy_vec);
    end
    step();
    clear = 1'b0;
    #1;
    checks++;
    if (cdb_valid !== 1'b0 || rdy_vec !== 3'b111) begin
      errors++;
      $display("FAIL flush_after: got v=%b ready=%b want v=0 ready=111", cdb_valid, rdy_vec);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (cdb_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_leak%0d: got v=%b id=%0d want v=0", c, cdb_valid, cdb_rob_id);
      end
    end
  endtask

  task automatic test_stall();
    flush_cycle();
    tv[0] = 1'b1; tid[0] = ROB_WIDTH'(3); tval[0] = 32'h0303;
    tv[1] = 1'b1; tid[1] = ROB_WIDTH'(4); tval[1] = 32'h0404;
    step();
    set_idle();
    step();
    rdy_in = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (rdy_vec !== 3'b000) begin
        errors++;
        $display("FAIL stall_ready%0d: got %b want 000", c, rdy_vec);
      end
      step();
      checks++;
      if (cdb_valid !== 1'b1 || cdb_src !== SRC_ALU || cdb_rob_id !== ROB_WIDTH'(3) ||
          cdb_value !== 32'h0303) begin
        errors++;
        $display("FAIL stall_frozen%0d: got v=%b src=%0d id=%0d want v=1 src=0 id=3",
                 c, cdb_valid, cdb_src, cdb_rob_id);
      end
    end
    rdy_in = 1'b1;
    step();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_src !== SRC_BR || cdb_rob_id !== ROB_WIDTH'(4) ||
        cdb_value !== 32'h0404) begin
      errors++;
      $display("FAIL stall_release: got v=%b src=%0d id=%0d want v=1 src=1 id=4",
               cdb_valid, cdb_src, cdb_rob_id);
    end
    step();
  endtask

  task automatic test_async_reset();
    flush_cycle();
    for (int i = 0; i < 3; i++) begin
      tv[i] = 1'b1; tid[i] = ROB_WIDTH'(11 + i); tval[i] = $urandom;
    end
    step();
    set_idle();
    step();
    #2;
    rst_in = 1'b1;
    #1;
    checks++;
    if (cdb_valid !== 1'b0 || rdy_vec !== 3'b000) begin
      errors++;
      $display("FAIL areset_immediate: got v=%b ready=%b want v=0 ready=000", cdb_valid, rdy_vec);
    end
    model_reset();
    #1;
    rst_in = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (cdb_valid !== 1'b0) begin
        errors++;
        $display("FAIL areset_leak%0d: got v=%b id=%0d want v=0", c, cdb_valid, cdb_rob_id);
      end
    end
    tv[2] = 1'b1; tid[2] = ROB_WIDTH'(7); tval[2] = 32'h7777;
    step();
    set_idle();
    step();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_src !== SRC_LSB || cdb_rob_id !== ROB_WIDTH'(7)) begin
      errors++;
      $display("FAIL areset_resume: got v=%b src=%0d id=%0d want v=1 src=2 id=7",
               cdb_valid, cdb_src, cdb_rob_id);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      rdy_in = ($urandom_range(0, 9) != 0);
      clear  = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < 3; i++) begin
        tv[i]   = ($urandom_range(0, 2) != 0);
        tid[i]  = ROB_WIDTH'($urandom);
        tval[i] = $urandom;
      end
      #1;
      checks++;
      if (rdy_vec !== m_ready()) begin
        errors++;
        $display("FAIL rand_ready%0d: got %b want %b", c, rdy_vec, m_ready());
      end
      step();
      checks++;
      if (cdb_valid !== m_cv || cdb_src !== m_src || cdb_rob_id !== m_cid ||
          cdb_value !== m_cval) begin
        errors++;
        $display("FAIL rand_cdb%0d: got v=%b src=%0d id=%0d val=%h want v=%b src=%0d id=%0d val=%h",
                 c, cdb_valid, cdb_src, cdb_rob_id, cdb_value, m_cv, m_src, m_cid, m_cval);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      tv[i] = 1'b0; tid[i] = '0; tval[i] = '0;
    end
    test_reset();
    test_solo_alu();
    test_collision();
    test_rotation();
    test_flush();
    test_stall();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
